// File: rtl/csoc_scan_engine_pkg.sv
// Shared definitions for the CSoC scan engine: op and state encodings and default timing.
package csoc_scan_engine_pkg;

  localparam int CLK_DIV_DEFAULT    = 4;
  localparam int RST_PULSES_DEFAULT = 2;

  typedef enum logic [1:0] {
    OP_SHIFT   = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_RESET   = 2'b10,
    OP_SET_TM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_LOW
  } phase_e;

  // Every op except SET_TM needs at least one csoc_clk pulse.
  function automatic logic is_pulse_op(op_e op);
    return op != OP_SET_TM;
  endfunction

endpackage

// File: rtl/csoc_scan_engine_if.sv
// Command and response channels between cmd_parser (master) and the scan engine (slave).
interface csoc_scan_engine_if;
  import csoc_scan_engine_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_e        cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/csoc_scan_engine_clk_pulse.sv
// Generates one csoc_clk pulse as SETUP (low), HIGH and LOW phases of CLK_DIV cycles each.
// Holding start_i on the last LOW cycle chains the next pulse straight into SETUP.
module csoc_scan_engine_clk_pulse
  import csoc_scan_engine_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic done_o,
  output logic sample_strobe_o,
  output logic csoc_clk_o
);

  localparam int            CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          csocClk_q;
  logic          isLast;

  assign isLast = (cnt_q == CNT_LAST);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    unique case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end
      end
      PH_SETUP: begin
        if (isLast) begin
          phase_d = PH_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH_HIGH: begin
        if (isLast) begin
          phase_d = PH_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH_LOW: begin
        if (isLast) begin
          phase_d = start_i ? PH_SETUP : PH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // csoc_clk comes straight from a flop so the CSoC never sees a combinational glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      csocClk_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      csocClk_q <= (phase_d == PH_HIGH);
    end
  end

  assign done_o          = (phase_q == PH_LOW) && isLast;
  assign sample_strobe_o = (phase_q == PH_SETUP) && isLast;
  assign csoc_clk_o      = csocClk_q;

endmodule

// File: rtl/csoc_scan_engine.sv
// Scan engine top: decodes one op per handshake, owns the CSoC pin registers and the response channel.
// The CSoC stays in reset (csoc_rstn low) until the first RESET op completes.
module csoc_scan_engine
  import csoc_scan_engine_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int RST_PULSES = RST_PULSES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  csoc_scan_engine_if.slave   bus,
  output logic                busy_o,
  output logic                csoc_clk_o,
  output logic                csoc_rstn_o,
  output logic                csoc_test_se_o,
  output logic                csoc_test_tm_o,
  output logic [7:0]          csoc_data_o,
  input  logic [7:0]          csoc_data_i
);

  localparam int            PW         = $clog2(RST_PULSES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSES - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [PW-1:0] pulseCnt_q, pulseCnt_d;
  logic          rstn_q, rstn_d;
  logic          se_q, se_d;
  logic          tm_q, tm_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rspData_q, rspData_d;
  logic          pulseStart;
  logic          pulseDone;
  logic          sampleStrobe;

  csoc_scan_engine_clk_pulse #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_pulse (
    .clk             (clk),
    .rst             (rst),
    .start_i         (pulseStart),
    .done_o          (pulseDone),
    .sample_strobe_o (sampleStrobe),
    .csoc_clk_o      (csoc_clk_o)
  );

  // Pin registers only change on accept, while csoc_clk is guaranteed low.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pulseCnt_d = pulseCnt_q;
    rstn_d     = rstn_q;
    se_d       = se_q;
    tm_d       = tm_q;
    data_d     = data_q;
    rspData_d  = rspData_q;
    pulseStart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          unique case (bus.cmd_op)
            OP_SHIFT: begin
              data_d = bus.cmd_data;
              se_d   = 1'b1;
            end
            OP_CAPTURE: se_d = 1'b0;
            OP_RESET: begin
              rstn_d     = 1'b0;
              se_d       = 1'b0;
              pulseCnt_d = '0;
            end
            OP_SET_TM: tm_d = bus.cmd_data[0];
            default: ;
          endcase
          if (is_pulse_op(bus.cmd_op)) begin
            pulseStart = 1'b1;
            state_d    = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (sampleStrobe && (op_q != OP_RESET)) begin
          rspData_d = csoc_data_i;
        end
        if (pulseDone) begin
          if (op_q != OP_RESET) begin
            state_d = ST_RESP;
          end else if (pulseCnt_q == PULSE_LAST) begin
            rstn_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pulseCnt_d = pulseCnt_q + PW'(1);
            pulseStart = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_SHIFT;
      pulseCnt_q <= '0;
      rstn_q     <= 1'b0;
      se_q       <= 1'b0;
      tm_q       <= 1'b0;
      data_q     <= '0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pulseCnt_q <= pulseCnt_d;
      rstn_q     <= rstn_d;
      se_q       <= se_d;
      tm_q       <= tm_d;
      data_q     <= data_d;
      rspData_q  <= rspData_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_data   = rspData_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign csoc_rstn_o    = rstn_q;
  assign csoc_test_se_o = se_q;
  assign csoc_test_tm_o = tm_q;
  assign csoc_data_o    = data_q;

endmodule

// File: tb/tb_csoc_scan_engine.sv
// Scoreboard bench for csoc_scan_engine: directed scenarios followed by random ops.
// Expected responses are queued at accept and popped by an independent monitor.
module tb_csoc_scan_engine;
  import csoc_scan_engine_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int RST_PULSES = 2;
  localparam int LAT        = 3 * CLK_DIV + 1;

  typedef struct {
    logic [7:0] data;
    int         riseCycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, csocClk, csocRstn, csocSe, csocTm;
  logic [7:0] csocDataO, csocDataI;

  csoc_scan_engine_if bus();

  csoc_scan_engine #(
    .CLK_DIV    (CLK_DIV),
    .RST_PULSES (RST_PULSES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .busy_o         (busy),
    .csoc_clk_o     (csocClk),
    .csoc_rstn_o    (csocRstn),
    .csoc_test_se_o (csocSe),
    .csoc_test_tm_o (csocTm),
    .csoc_data_o    (csocDataO),
    .csoc_data_i    (csocDataI)
  );

  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  int   rspMode = 2;
  int   lastT0 = 0;
  int   lastPopCycle = 0;
  exp_t expQ[$];
  exp_t popped;

  // Reference pin state, derived only from the ops the bench has issued.
  logic       mSe = 1'b0;
  logic       mTm = 1'b0;
  logic       mRstn = 1'b0;
  logic [7:0] mData = 8'h00;

  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic       prevClk = 1'b0;
  logic       prevSe = 1'b0;
  logic [7:0] prevRspData = 8'h00;
  logic [7:0] prevDataO = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cycleCount);
    end
  endtask

  // rsp_ready changes just after the rising edge: 0 random, 1 held low, otherwise held high.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rspMode)
        0:       bus.rsp_ready = 1'($urandom_range(0, 1));
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // Response monitor: latency on rise, stability under backpressure, data on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && !prevValid) begin
        checkOutput("rsp_pending", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          checkOutput("rsp_latency", cycleCount, expQ[0].riseCycle);
        end
      end
      if (bus.rsp_valid && prevValid && !prevReady) begin
        checkOutput("rsp_stable", bus.rsp_data, prevRspData);
      end
      if (bus.rsp_valid && bus.rsp_ready && (expQ.size() != 0)) begin
        popped = expQ.pop_front();
        checkOutput("rsp_data", bus.rsp_data, popped.data);
        lastPopCycle = cycleCount;
      end
      if (prevClk && csocClk) begin
        checkOutput("se_stable_clk_high", csocSe, prevSe);
        checkOutput("data_stable_clk_high", csocDataO, prevDataO);
      end
    end
    prevValid   = bus.rsp_valid;
    prevReady   = bus.rsp_ready;
    prevRspData = bus.rsp_data;
    prevClk     = csocClk;
    prevSe      = csocSe;
    prevDataO   = csocDataO;
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", busy, 0);
  endtask

  // Issues one op at a negedge; returns at the negedge one cycle after the accept edge.
  task automatic applyStimulus(input op_e op, input logic [7:0] data, input logic [7:0] sampleVal);
    int   n;
    int   pulses;
    int   highRun;
    logic prevC;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept actual=ready_low expected=ready_high cycle=%0d", cycleCount);
      bus.cmd_valid = 1'b0;
      return;
    end
    csocDataI = sampleVal;
    lastT0    = cycleCount;
    case (op)
      OP_SHIFT: begin
        mSe   = 1'b1;
        mData = data;
        expQ.push_back('{data: sampleVal, riseCycle: cycleCount + LAT});
      end
      OP_CAPTURE: begin
        mSe = 1'b0;
        expQ.push_back('{data: sampleVal, riseCycle: cycleCount + LAT});
      end
      OP_RESET: begin
        mSe   = 1'b0;
        mRstn = 1'b0;
      end
      default: mTm = data[0];
    endcase
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("pin_se", csocSe, mSe);
    checkOutput("pin_data_o", csocDataO, mData);
    checkOutput("pin_tm", csocTm, mTm);
    checkOutput("pin_rstn", csocRstn, mRstn);
    checkOutput("busy_after_accept", busy, op != OP_SET_TM);
    checkOutput("cmd_ready_after_accept", bus.cmd_ready, op == OP_SET_TM);
    if (op == OP_RESET) begin
      pulses  = 0;
      highRun = 0;
      prevC   = 1'b0;
      n       = 0;
      while (busy && n < 2000) begin
        checkOutput("reset_rstn_low", csocRstn, 0);
        if (csocClk) begin
          highRun++;
        end else if (prevC) begin
          pulses++;
          checkOutput("reset_high_len", highRun, CLK_DIV);
          highRun = 0;
        end
        prevC = csocClk;
        @(negedge clk);
        n++;
      end
      checkOutput("reset_pulses", pulses, RST_PULSES);
      checkOutput("reset_rstn_released", csocRstn, 1);
      mRstn = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished cycle=%0d", cycleCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_SHIFT;
    bus.cmd_data  = 8'h00;
    csocDataI     = 8'h00;
    rspMode       = 2;
    repeat (3) @(negedge clk);
    checkOutput("rst_clk", csocClk, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;

    $display("[TB] reset idle window");
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_clk", csocClk, 0);
      checkOutput("idle_rstn", csocRstn, 0);
      checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
      checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk);
    end
    checkOutput("idle_se", csocSe, 0);
    checkOutput("idle_tm", csocTm, 0);
    checkOutput("idle_data_o", csocDataO, 0);
    checkOutput("idle_rsp_data", bus.rsp_data, 0);

    $display("[TB] directed SHIFT");
    applyStimulus(OP_SHIFT, 8'h3C, 8'h81);
    for (int k = 1; k <= 3 * CLK_DIV; k++) begin
      checkOutput("shift_clk_trace", csocClk, (k > CLK_DIV) && (k <= 2 * CLK_DIV));
      checkOutput("shift_no_rsp_yet", bus.rsp_valid, 0);
      @(negedge clk);
    end
    checkOutput("shift_rsp_valid", bus.rsp_valid, 1);
    checkOutput("shift_rsp_data", bus.rsp_data, 8'h81);
    waitIdle();

    $display("[TB] directed RESET");
    applyStimulus(OP_RESET, 8'h00, 8'h00);

    $display("[TB] SET_TM and CAPTURE");
    applyStimulus(OP_SET_TM, 8'h01, 8'h00);
    applyStimulus(OP_CAPTURE, 8'hFF, 8'h96);
    n = 0;
    while (busy && n < 2000) begin
      checkOutput("capture_se_low", csocSe, 0);
      checkOutput("capture_tm_high", csocTm, 1);
      @(negedge clk);
      n++;
    end
    checkOutput("capture_done", busy, 0);
    applyStimulus(OP_SET_TM, 8'h00, 8'h00);

    $display("[TB] backpressure");
    rspMode = 1;
    applyStimulus(OP_SHIFT, 8'h5A, 8'hC3);
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_op    = OP_CAPTURE;
    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_rsp_data", bus.rsp_data, 8'hC3);
      checkOutput("bp_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end
    rspMode = 2;
    applyStimulus(OP_CAPTURE, 8'h00, 8'h3E);
    checkOutput("bp_accept_after_ready", lastT0 > lastPopCycle, 1);
    waitIdle();

    $display("[TB] reset during HIGH");
    applyStimulus(OP_SHIFT, 8'hA5, 8'h77);
    n = 0;
    while (!csocClk && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reached_high", csocClk, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_clk", csocClk, 0);
    checkOutput("midrst_se", csocSe, 0);
    checkOutput("midrst_data_o", csocDataO, 0);
    checkOutput("midrst_rstn", csocRstn, 0);
    checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    expQ.delete();
    mSe   = 1'b0;
    mTm   = 1'b0;
    mRstn = 1'b0;
    mData = 8'h00;
    for (int i = 0; i < LAT + 4; i++) begin
      checkOutput("midrst_no_rsp", bus.rsp_valid, 0);
      @(negedge clk);
    end
    applyStimulus(OP_RESET, 8'h00, 8'h00);

    $display("[TB] random ops");
    rspMode = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(op_e'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    rspMode = 2;
    waitIdle();
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
